// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming(16,11) link: widths, parity
// coverage masks, transmitter FSM encoding and the reference encoder function.
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int PKT_W  = 16;

    // Parity coverage over packet bit indices (bit index = 15 - position).
    localparam logic [PKT_W-1:0] P1_MASK = 16'h1555;
    localparam logic [PKT_W-1:0] P2_MASK = 16'h1333;
    localparam logic [PKT_W-1:0] P4_MASK = 16'h070F;
    localparam logic [PKT_W-1:0] P8_MASK = 16'h007F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    function automatic logic [PKT_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [PKT_W-1:0] w;
        w        = '0;
        w[12]    = d[10];
        w[10:8]  = d[9:7];
        w[6:0]   = d[6:0];
        // Parity slots are still zero here, so the masks see data bits only.
        w[14]    = ^(w & P1_MASK);
        w[13]    = ^(w & P2_MASK);
        w[11]    = ^(w & P4_MASK);
        w[7]     = ^(w & P8_MASK);
        w[15]    = ^w[14:0];
        return w;
    endfunction

endpackage

// File: rtl/hamming_enc_tx_if.sv
// Valid/ready word handshake into the Hamming transmitter.
interface hamming_enc_tx_if;

    logic [hamming_pkg::DATA_W-1:0] data;
    logic                           in_valid;
    logic                           in_ready;

    modport master (output data, output in_valid, input in_ready);
    modport slave  (input data, input in_valid, output in_ready);

endinterface

// File: rtl/hamming_enc_core.sv
// Purely combinational extended-Hamming(16,11) encoder.
module hamming_enc_core
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [PKT_W-1:0]  code
);

    assign code = hamming_encode(data);

endmodule

// File: rtl/hamming_enc_tx.sv
// Hamming(16,11) encoder feeding an MSB-first SPI mode-0 transmitter.
// Optional HAMMING_ERR_INJECT_EN adds err_mask, XORed onto the serial word only.
module hamming_enc_tx
    import hamming_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 4
) (
    input  logic              clk,
    input  logic              rst,
    hamming_enc_tx_if.slave   bus,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [PKT_W-1:0]  err_mask,
`endif
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    output logic [3:0]        state,
    output logic              busy,
    output logic              done,
    output logic [PKT_W-1:0]  packet
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP - 2);

    tx_state_e        fsm;
    logic [PKT_W-1:0] code;
    logic [PKT_W-1:0] serial;
    logic [14:0]      tx_word;
    logic [15:0]      div_cnt;
    logic [15:0]      gap_cnt;

    hamming_enc_core u_core (
        .data (bus.data),
        .code (code)
    );

`ifdef HAMMING_ERR_INJECT_EN
    assign serial = code ^ err_mask;
`else
    assign serial = code;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked block and every
    // register, including the packet holding register, gets a defined value.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= ST_IDLE;
            bus.in_ready <= 1'b0;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            state        <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            packet       <= '0;
            tx_word      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        packet       <= code;
                        mosi         <= serial[15];
                        tx_word      <= serial[14:0];
                        cs_n         <= 1'b0;
                        sclk         <= 1'b0;
                        state        <= 4'd0;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b0;
                        div_cnt      <= '0;
                        fsm          <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (state == 4'd15) begin
                                done  <= 1'b1;
                                cs_n  <= 1'b1;
                                mosi  <= 1'b0;
                                state <= 4'd0;
                                // in_ready rises one cycle before the next accept,
                                // so cs_n stays high for exactly GAP cycles.
                                if (GAP == 1) begin
                                    busy         <= 1'b0;
                                    bus.in_ready <= 1'b1;
                                    fsm          <= ST_IDLE;
                                end else begin
                                    gap_cnt <= '0;
                                    fsm     <= ST_GAP;
                                end
                            end else begin
                                state   <= state + 4'd1;
                                mosi    <= tx_word[14];
                                tx_word <= {tx_word[13:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                        fsm          <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Directed self-checking bench for hamming_enc_tx; build with +define+HAMMING_ERR_INJECT_EN
// to include the error-injection vector.
module tb_hamming_enc_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 4;
    localparam int BUDGET  = 40 * CLK_DIV + 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n, sclk, mosi, busy, done;
    logic [3:0]  state;
    logic [15:0] packet;
`ifdef HAMMING_ERR_INJECT_EN
    logic [15:0] err_mask = 16'h0000;
`endif

    int checks = 0;
    int errors = 0;

    hamming_enc_tx_if bif ();

    hamming_enc_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bif),
`ifdef HAMMING_ERR_INJECT_EN
        .err_mask (err_mask),
`endif
        .cs_n   (cs_n),
        .sclk   (sclk),
        .mosi   (mosi),
        .state  (state),
        .busy   (busy),
        .done   (done),
        .packet (packet)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents the word, and checks the state right after the accept edge.
    task automatic accept_word(input logic [10:0] d, input logic [15:0] exp_pkt,
                               input logic exp_first, input logic hold, input string tag);
        int n;
        n = 0;
        while (bif.in_ready !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(n < BUDGET), 32'd1);
        bif.data     = d;
        bif.in_valid = 1'b1;
        tick();
        if (!hold) bif.in_valid = 1'b0;
        check({tag, "_packet"}, 32'(packet), 32'(exp_pkt));
        check({tag, "_start"}, {28'd0, cs_n, busy, bif.in_ready, mosi},
              {28'd0, 1'b0, 1'b1, 1'b0, exp_first});
        check({tag, "_state0"}, 32'(state), 32'd0);
    endtask

    // Follows one frame from just after accept to the done pulse.
    task automatic run_frame(input logic [15:0] exp_serial, input logic [15:0] exp_pkt,
                             input string tag);
        int n, rises, state_err, unstable, cs_high;
        logic [15:0] cap;
        logic prev_sclk, hold_bit, seen_done;
        n = 0; rises = 0; state_err = 0; unstable = 0; cs_high = 0;
        cap = '0; prev_sclk = sclk; hold_bit = 1'b0; seen_done = 1'b0;
        while (!seen_done && n < BUDGET) begin
            tick();
            n++;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (cs_n) cs_high++;
                if (sclk && !prev_sclk) begin
                    if (state != 4'(rises)) state_err++;
                    cap      = {cap[14:0], mosi};
                    hold_bit = mosi;
                    rises++;
                end else if (sclk && mosi != hold_bit) begin
                    unstable++;
                end
                prev_sclk = sclk;
            end
        end
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_frame_len"}, 32'(n), 32'(32 * CLK_DIV));
        check({tag, "_rises"}, 32'(rises), 32'd16);
        check({tag, "_serial"}, 32'(cap), 32'(exp_serial));
        check({tag, "_state_at_rise"}, 32'(state_err), 32'd0);
        check({tag, "_mosi_stable"}, 32'(unstable), 32'd0);
        check({tag, "_cs_low"}, 32'(cs_high), 32'd0);
        check({tag, "_end_pins"}, {29'd0, cs_n, sclk, mosi}, {29'd0, 3'b100});
        check({tag, "_pkt_held"}, 32'(packet), 32'(exp_pkt));
    endtask

    initial begin
        int g;
        bif.data     = '0;
        bif.in_valid = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_pins", {28'd0, cs_n, sclk, mosi, bif.in_ready}, {28'd0, 4'b1000});
        check("rst_status", {27'd0, busy, done, state}, 32'd0);
        check("rst_packet", 32'(packet), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_ready_after", 32'(bif.in_ready), 32'd1);

        // All-zero and all-one words
        accept_word(11'h000, 16'h0000, 1'b0, 1'b0, "zero");
        run_frame(16'h0000, 16'h0000, "zero");
        accept_word(11'h7FF, 16'hFFFF, 1'b1, 1'b0, "ones");
        run_frame(16'hFFFF, 16'hFFFF, "ones");

        // Single data bits at both ends of the word
        accept_word(11'h001, 16'hE881, 1'b1, 1'b0, "d001");
        run_frame(16'hE881, 16'hE881, "d001");
        accept_word(11'h400, 16'hF000, 1'b1, 1'b0, "d400");
        run_frame(16'hF000, 16'hF000, "d400");

        // Back-to-back with in_valid held; the data change mid-frame must not disturb frame 1
        accept_word(11'h400, 16'hF000, 1'b1, 1'b1, "b2b1");
        bif.data = 11'h001;
        run_frame(16'hF000, 16'hF000, "b2b1");
        g = 1;
        while (cs_n && g < BUDGET) begin
            tick();
            if (cs_n) g++;
        end
        check("b2b_gap", 32'(g), 32'(GAP));
        check("b2b2_packet", 32'(packet), 32'hE881);
        check("b2b2_state0", 32'(state), 32'd0);
        bif.in_valid = 1'b0;
        run_frame(16'hE881, 16'hE881, "b2b2");

        // Reset in the middle of a frame
        accept_word(11'h7FF, 16'hFFFF, 1'b1, 1'b0, "mid");
        g = 0;
        while (state != 4'd7 && g < BUDGET) begin
            tick();
            g++;
        end
        check("mid_reach_bit7", 32'(g < BUDGET), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_pins", {27'd0, cs_n, sclk, state}, {27'd0, 1'b1, 1'b0, 4'd0});
        check("mid_rst_status", {29'd0, busy, bif.in_ready, mosi}, 32'd0);
        check("mid_rst_packet", 32'(packet), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_ready_after", 32'(bif.in_ready), 32'd1);
        accept_word(11'h400, 16'hF000, 1'b1, 1'b0, "post");
        run_frame(16'hF000, 16'hF000, "post");

`ifdef HAMMING_ERR_INJECT_EN
        // Bit 2 flipped on the wire only
        err_mask = 16'h0004;
        accept_word(11'h001, 16'hE881, 1'b1, 1'b0, "inj");
        err_mask = 16'h0000;
        run_frame(16'hE885, 16'hE881, "inj");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
